// File: rtl/digit_scan.sv
// digit_scan: 4-digit multiplexed display scanner with frame-synchronous value update.
// Each digit slot lasts CLK_DIV cycles. The first DEAD cycles of a slot are blank so
// segment drivers can settle without ghosting into the neighbouring digit.
// A new value is held in a shadow register and moved to the display register only at
// the frame boundary, so a frame never shows a mix of old and new digits.
// Optional feature: define DIGIT_SCAN_LZB_EN to compile in leading-zero blanking.
module digit_scan #(
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  num,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        pending,
  output logic        frame_done
);

  localparam int                CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_C  = CNT_W'(DEAD);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_disp;
  logic [15:0]      r_pend;
  logic             r_pending;
  logic             r_frame_done;

  logic             w_cnt_wrap;
  logic             w_boundary;
  logic             w_slot_blank;
  logic             w_active;
  logic [3:0]       w_onehot;

  assign w_cnt_wrap = (r_cnt == CNT_MAX);
  assign w_boundary = w_cnt_wrap && (r_idx == 2'd3);

  // Prescaler, slot index, display/shadow registers and frame pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_disp       <= 16'h0000;
      r_pend       <= 16'h0000;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      r_frame_done <= w_boundary;
      if (w_cnt_wrap) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_boundary) begin
        // A load landing on the boundary bypasses the shadow and wins over it.
        if (load) begin
          r_disp <= value;
        end else if (r_pending) begin
          r_disp <= r_pend;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pend    <= value;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef DIGIT_SCAN_LZB_EN
  // Leading-zero blanking: slot k (k>0) is dark when every nibble from k upward is zero.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_slot_blank = 1'b0;
    case (r_idx)
      2'd1:    w_slot_blank = (r_disp[15:4]  == 12'h000);
      2'd2:    w_slot_blank = (r_disp[15:8]  == 8'h00);
      2'd3:    w_slot_blank = (r_disp[15:12] == 4'h0);
      default: w_slot_blank = 1'b0;
    endcase
  end
`else
  assign w_slot_blank = 1'b0;
`endif

  // Output decode straight from registered state: zero latency from cnt/idx.
  always_comb begin
    w_onehot = 4'b0001 << r_idx;
    w_active = (r_cnt >= DEAD_C) && !w_slot_blank;
  end

  assign digit      = w_active ? w_onehot : 4'b0000;
  assign blank      = !w_active;
  assign num        = r_disp[{r_idx, 2'b00} +: 4];
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: directed bench for digit_scan with CLK_DIV=8, DEAD=2.
// Expected per-cycle outputs of each frame are pushed to a scoreboard queue from the
// expected display value and load schedule, then popped and compared as the DUT runs.
module tb_digit_scan;

  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  num;
  logic [3:0]  digit;
  logic        blank;
  logic        pending;
  logic        frame_done;

  typedef struct packed {
    logic       fd;
    logic       pending;
    logic       blank;
    logic [3:0] digit;
    logic [3:0] num;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  digit_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .num        (num),
    .digit      (digit),
    .blank      (blank),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run ncyc cycles starting at cnt=0, idx=0 with display value disp_exp.
  // Loads of va at cycle la and vb at cycle lb (-1 = none) are applied on the way.
  task automatic run_frame(input string name, input logic [15:0] disp_exp, input logic fd0,
                           input logic pend0, input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb, input int ncyc);
    logic p;
    p = pend0;
    for (int c = 0; c < ncyc; c++) begin
      exp_t e;
      int   slot;
      int   pos;
      logic bl;
      slot = c / CLK_DIV;
      pos  = c % CLK_DIV;
      bl   = (pos < DEAD);
`ifdef DIGIT_SCAN_LZB_EN
      if (slot > 0 && (disp_exp >> (4 * slot)) == 16'h0000) bl = 1'b1;
`endif
      e.fd      = (c == 0) ? fd0 : 1'b0;
      e.pending = p;
      e.blank   = bl;
      e.digit   = bl ? 4'b0000 : 4'(1 << slot);
      e.num     = disp_exp[4*slot +: 4];
      sb_q.push_back(e);
      if (c == FRAME - 1) p = 1'b0;
      else if (c == la || c == lb) p = 1'b1;
    end

    for (int c = 0; c < ncyc; c++) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("%s c%0d", name, c),
            32'({frame_done, pending, blank, digit, num}), 32'(e));
      if (c == la) begin
        load  = 1'b1;
        value = va;
      end else if (c == lb) begin
        load  = 1'b1;
        value = vb;
      end
      step();
      load  = 1'b0;
      value = 16'h0000;
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    step();
    step();
    check("rst_digit",   32'(digit),      32'h0);
    check("rst_blank",   32'(blank),      32'h1);
    check("rst_num",     32'(num),        32'h0);
    check("rst_pending", 32'(pending),    32'h0);
    check("rst_fdone",   32'(frame_done), 32'h0);
    reset = 1'b0;

    // Plain scan after reset.
    run_frame("scan", 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    // Load 1234h mid-slot 1; display stays 0 until the boundary.
    run_frame("ld1234", 16'h0000, 1'b1, 1'b0, 11, 16'h1234, -1, 16'h0, FRAME);
    run_frame("show1234", 16'h1234, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    // Two loads before the boundary: last one wins.
    run_frame("ld2", 16'h1234, 1'b1, 1'b0, 5, 16'hABCD, 20, 16'h5678, FRAME);
    // Load exactly at the boundary goes straight to the display.
    run_frame("show5678", 16'h5678, 1'b1, 1'b0, FRAME - 1, 16'h00F0, -1, 16'h0, FRAME);
    run_frame("show00F0", 16'h00F0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    // Reset in cycle 5 of slot 2 with a value pending.
    run_frame("prerst", 16'h00F0, 1'b1, 1'b0, 3, 16'h9999, -1, 16'h0, 2 * CLK_DIV + 5);
    check("prerst_pending", 32'(pending), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_digit",   32'(digit),      32'h0);
    check("mid_blank",   32'(blank),      32'h1);
    check("mid_num",     32'(num),        32'h0);
    check("mid_pending", 32'(pending),    32'h0);
    check("mid_fdone",   32'(frame_done), 32'h0);
    // Scan restarts from cnt=0/idx=0 with a cleared display and no stale pending value.
    run_frame("postrst", 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    check("postrst_fdone", 32'(frame_done), 32'h1);
    check("postrst_num",   32'(num),        32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
